cluster_evt_cdc_dst: RTL and testbench

CLUSTER_EVT_CDC_DST -- requirements
Module: cluster_evt_cdc_dst

---
 rtl/cluster_evt_cdc_dst.sv | 87 ++++++++
 tb/tb_cluster_evt_cdc_dst.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_evt_cdc_dst.sv
// Destination side of the cluster event async FIFO: syncs wptr, pops into a 1-entry output reg.
// Latency SYNC_STAGES+1 edges from wptr change to valid; holds data under !ready; isolate_i blocks pops.
module cluster_evt_cdc_dst #(
  parameter int unsigned LOG_DEPTH   = 3,
  parameter int unsigned EVNT_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic [LOG_DEPTH:0]                          async_cluster_events_wptr_i,
  input  logic [EVNT_WIDTH-1:0][(2**LOG_DEPTH)-1:0]   async_cluster_events_data_i,
  output logic [LOG_DEPTH:0]                          async_cluster_events_rptr_o,
  input  logic                                        isolate_i,
  output logic                                        evt_valid_o,
  input  logic                                        evt_ready_i,
  output logic [EVNT_WIDTH-1:0]                       evt_data_o,
  output logic                                        evt_pending_o
);

  localparam int unsigned PTR_W = LOG_DEPTH + 1;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SYNC_STAGES-1:0][PTR_W-1:0] wsync_q;
  logic [PTR_W-1:0]                  wptr_sync;
  logic [PTR_W-1:0]                  rd_bin_q, rd_bin_d, rd_bin_inc;
  logic [PTR_W-1:0]                  rptr_q, rptr_d;
  logic                              out_valid_q, out_valid_d;
  logic [EVNT_WIDTH-1:0]             data_q, data_d;
  logic [EVNT_WIDTH-1:0]             pop_data;
  logic [LOG_DEPTH-1:0]              rd_idx;
  logic                              empty;
  logic                              pop;

  assign wptr_sync  = wsync_q[SYNC_STAGES-1];
  assign rd_bin_inc = rd_bin_q + {{LOG_DEPTH{1'b0}}, 1'b1};
  assign rd_idx     = rd_bin_q[LOG_DEPTH-1:0];
  assign empty      = (bin2gray(rd_bin_q) == wptr_sync);
  assign pop        = !empty && !isolate_i && (!out_valid_q || evt_ready_i);

  // Storage is bit-major, so the popped word is gathered one bit-plane at a time.
  always_comb begin
    pop_data = '0;
    for (int b = 0; b < EVNT_WIDTH; b++) begin
      pop_data[b] = async_cluster_events_data_i[b][rd_idx];
    end
  end

  always_comb begin
    rd_bin_d    = rd_bin_q;
    rptr_d      = rptr_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    if (pop) begin
      rd_bin_d    = rd_bin_inc;
      rptr_d      = bin2gray(rd_bin_inc);
      out_valid_d = 1'b1;
      data_d      = pop_data;
    end else if (evt_valid_o && evt_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wsync_q     <= '0;
      rd_bin_q    <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      wsync_q     <= {wsync_q[SYNC_STAGES-2:0], async_cluster_events_wptr_i};
      rd_bin_q    <= rd_bin_d;
      rptr_q      <= rptr_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
    end
  end

  assign async_cluster_events_rptr_o = rptr_q;
  assign evt_data_o                  = data_q;
  assign evt_valid_o                 = out_valid_q && !isolate_i;
  assign evt_pending_o               = !empty || out_valid_q;

endmodule

// File: tb/tb_cluster_evt_cdc_dst.sv
// Bench for cluster_evt_cdc_dst: directed vector table, hand sequences, then random traffic vs a model.
module tb_cluster_evt_cdc_dst;
  localparam int LD = 3;
  localparam int EW = 8;
  localparam int SS = 2;
  localparam int DEPTH = 2 ** LD;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [LD:0]       wptr;
  logic [EW-1:0][DEPTH-1:0] data;
  logic [LD:0]       rptr;
  logic              iso;
  logic              vld;
  logic              rdy;
  logic [EW-1:0]     dat;
  logic              pend;

  cluster_evt_cdc_dst #(.LOG_DEPTH(LD), .EVNT_WIDTH(EW), .SYNC_STAGES(SS)) dut (
    .clk_i                       (clk_i),
    .rst_ni                      (rst_ni),
    .async_cluster_events_wptr_i (wptr),
    .async_cluster_events_data_i (data),
    .async_cluster_events_rptr_o (rptr),
    .isolate_i                   (iso),
    .evt_valid_o                 (vld),
    .evt_ready_i                 (rdy),
    .evt_data_o                  (dat),
    .evt_pending_o               (pend)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] mem [DEPTH];

  // Reference: counts of written/read events, an output slot, and a wptr delay line.
  int            m_rd;
  bit            m_valid;
  logic [EW-1:0] m_data;
  logic [LD:0]   m_hist[$];
  logic [LD:0]   m_wsync;
  int            wr_cnt;

  function automatic logic [LD:0] b2g(input int b);
    logic [LD:0] v;
    v = LD'(0) + (LD+1)'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [LD:0] g);
    int r;
    r = 0;
    for (int i = LD; i >= 0; i--) r = (r << 1) | (((r & 1) ^ int'(g[i])) & 1);
    return r;
  endfunction

  function automatic int m_avail();
    return (g2b(m_wsync) - m_rd) & (2 * DEPTH - 1);
  endfunction

  task automatic pack();
    for (int b = 0; b < EW; b++)
      for (int k = 0; k < DEPTH; k++)
        data[b][k] = mem[k][b];
  endtask

  task automatic tick();
    if (!rst_ni) begin
      m_rd = 0; m_valid = 0; m_data = '0; m_wsync = '0;
      m_hist = {};
      for (int i = 0; i < SS; i++) m_hist.push_back('0);
    end else begin
      if (m_avail() != 0 && !iso && (!m_valid || rdy)) begin
        m_data  = mem[m_rd % DEPTH];
        m_valid = 1;
        m_rd    = (m_rd + 1) % (2 * DEPTH);
      end else if (m_valid && !iso && rdy) begin
        m_valid = 0;
      end
      m_hist.push_back(wptr);
      void'(m_hist.pop_front());
      m_wsync = m_hist[0];
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; wptr = '0; wr_cnt = 0;
    tick();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit          rst_n;
    logic [LD:0] wptr;
    bit          iso;
    bit          rdy;
    bit          e_vld;
    logic [7:0]  e_dat;
    logic [LD:0] e_rptr;
    bit          e_pend;
  } vec_t;

  vec_t tbl[17];

  initial begin
    //                rst wptr     iso rdy  vld data   rptr     pend
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1};
    tbl[3]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 8'hA5, 4'b0001, 1'b1};
    tbl[4]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 8'hA5, 4'b0001, 1'b0};
    tbl[5]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'hA5, 4'b0001, 1'b0};
    tbl[6]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'hA5, 4'b0001, 1'b1};
    tbl[7]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'hA5, 4'b0001, 1'b1};
    tbl[8]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, 8'h3C, 4'b0011, 1'b1};
    tbl[9]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 8'h3C, 4'b0011, 1'b1};
    tbl[10] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 8'hC3, 4'b0010, 1'b1};
    tbl[11] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 8'hC3, 4'b0010, 1'b0};
    tbl[12] = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hC3, 4'b0010, 1'b0};
    tbl[13] = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'hC3, 4'b0010, 1'b1};
    tbl[14] = '{1'b1, 4'b0100, 1'b0, 1'b0, 1'b1, 8'h5A, 4'b0110, 1'b1};
    tbl[15] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0};

    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hC3; mem[3] = 8'h5A;
    mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
    pack();
    rst_ni = 1'b0; wptr = '0; iso = 1'b0; rdy = 1'b1; wr_cnt = 0;

    for (int i = 0; i < 17; i++) begin
      rst_ni = tbl[i].rst_n; wptr = tbl[i].wptr; iso = tbl[i].iso; rdy = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_data", i), 32'(dat), 32'(tbl[i].e_dat));
      chk($sformatf("tbl%0d_rptr", i), 32'(rptr), 32'(tbl[i].e_rptr));
      chk($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].e_pend));
    end

    // Back-to-back: 8 entries at once, drained at one per cycle.
    do_reset();
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom);
    pack();
    wptr = 4'b1100; rdy = 1'b1; iso = 1'b0;
    tick(); tick();
    chk("b2b_prevalid", 32'(vld), 32'd0);
    chk("b2b_prepend", 32'(pend), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      chk($sformatf("b2b%0d_valid", k), 32'(vld), 32'd1);
      chk($sformatf("b2b%0d_data", k), 32'(dat), 32'(mem[k]));
    end
    chk("b2b_rptr", 32'(rptr), 32'b1100);
    tick();
    chk("b2b_done_valid", 32'(vld), 32'd0);
    chk("b2b_done_pend", 32'(pend), 32'd0);

    // Backpressure: 3 entries held behind ready low, then drained.
    do_reset();
    for (int k = 0; k < 3; k++) mem[k] = 8'($urandom);
    pack();
    wptr = 4'b0010; rdy = 1'b0;
    tick(); tick(); tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid", 32'(vld), 32'd1);
      chk("bp_data", 32'(dat), 32'(mem[0]));
      chk("bp_rptr", 32'(rptr), 32'b0001);
      chk("bp_pend", 32'(pend), 32'd1);
    end
    rdy = 1'b1;
    tick();
    chk("bp_rel1_valid", 32'(vld), 32'd1);
    chk("bp_rel1_data", 32'(dat), 32'(mem[1]));
    tick();
    chk("bp_rel2_valid", 32'(vld), 32'd1);
    chk("bp_rel2_data", 32'(dat), 32'(mem[2]));
    tick();
    chk("bp_rel3_valid", 32'(vld), 32'd0);
    chk("bp_rel3_pend", 32'(pend), 32'd0);
    chk("bp_rel3_rptr", 32'(rptr), 32'b0010);

    // Random traffic against the reference, with one mid-stream reset.
    do_reset();
    for (int c = 0; c < 900; c++) begin
      if (c == 450) begin
        rst_ni = 1'b0; wptr = '0; wr_cnt = 0;
      end else begin
        rst_ni = 1'b1;
        rdy = ($urandom_range(0, 9) < 7);
        iso = ($urandom_range(0, 9) == 0);
        if (((wr_cnt - m_rd) & (2 * DEPTH - 1)) < DEPTH && $urandom_range(0, 1) == 1) begin
          mem[wr_cnt % DEPTH] = 8'($urandom);
          pack();
          wr_cnt = (wr_cnt + 1) % (2 * DEPTH);
          wptr = b2g(wr_cnt);
        end
      end
      tick();
      chk("rnd_valid", 32'(vld), 32'(m_valid && !iso));
      chk("rnd_data", 32'(dat), 32'(m_data));
      chk("rnd_rptr", 32'(rptr), 32'(b2g(m_rd)));
      chk("rnd_pend", 32'(pend), 32'((m_avail() != 0) || m_valid));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
